// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for the EX stage: MUL/MULH/MULHSU/MULHU.
// Magnitudes are multiplied over WIDTH cycles and the sign is applied once at the end.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

  // Only funct3[1:0] selects the op; bit 2 is the M-extension div/mul split upstream.
  logic unused_funct3;
  assign unused_funct3 = funct3[2];

  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
  assign a_signed = funct3[1] ^ funct3[0];
  assign b_signed = (funct3[1:0] == 2'b01);
  assign a_neg    = a_signed & a[WIDTH-1];
  assign b_neg    = b_signed & b[WIDTH-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;
    prod     = neg_q ? -acc_q : acc_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          neg_d    = a_neg ^ b_neg;
          op_d     = funct3[1:0];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!kill) begin
          result_d = (op_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      op_q     <= 2'b00;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: vector table, corner sequences and a random sweep,
// with expected results queued at issue time and checked when done pulses.
module tb_seq_multiplier;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, kill;
  logic [2:0]   funct3;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[10];

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
    logic xs, ys;
    logic signed [65:0] sx, sy, p;
    xs = (f[1:0] == 2'b01) || (f[1:0] == 2'b10);
    ys = (f[1:0] == 2'b01);
    sx = {{34{xs & x[31]}}, x};
    sy = {{34{ys & y[31]}}, y};
    p  = sx * sy;
    return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Monitor: pops the scoreboard on every done pulse and checks value and arrival cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        n_done++;
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 with no op pending (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("latency", cyc, e.at);
        end
      end
    end
  end

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input bit expect_done);
    exp_t e;
    funct3 = f;
    a      = x;
    b      = y;
    start  = 1'b1;
    if (expect_done) begin
      e.res = exp;
      e.at  = cyc + W + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    check({"drain_", name}, sb.size(), 0);
  endtask

  int d0;
  logic [2:0]  rf;
  logic [31:0] rx, ry;

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vecs[0] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[1] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[5] = '{3'b001, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[6] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    vecs[7] = '{3'b100, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F};
    vecs[8] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9] = '{3'b001, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};

    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic MUL with busy-width check
    busy_cnt = 0;
    issue(3'b000, 32'd7, 32'd6, 32'h0000_002A, 1'b1);
    drain("mul7x6");
    check("busy_cycles", busy_cnt, 33);

    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].x, vecs[i].y, vecs[i].exp, 1'b1);
      drain("table");
    end

    // Back-to-back: second start in the done cycle, extra starts while busy ignored
    d0 = n_done;
    issue(3'b000, 32'd3, 32'd5, 32'h0000_000F, 1'b1);
    repeat (33) @(negedge clk);
    check("b2b_done_cycle", done, 1);
    issue(3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    repeat (5) @(negedge clk);
    funct3 = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    drain("b2b");
    repeat (40) @(negedge clk);
    check("b2b_done_count", n_done - d0, 2);

    // Kill mid-CALC: no done, result held
    issue(3'b000, 32'd3, 32'd5, 32'h0000_000F, 1'b1);
    drain("pre_kill");
    d0 = n_done;
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    repeat (9) @(negedge clk);
    check("kill_busy_before", busy, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy_after", busy, 0);
    repeat (40) @(negedge clk);
    check("kill_no_done", n_done - d0, 0);
    check("kill_result_held", result, 32'h0000_000F);
    issue(3'b000, 32'd2, 32'd9, 32'h0000_0012, 1'b1);
    drain("post_kill");

    // start together with kill in IDLE is dropped
    funct3 = 3'b000; a = 32'd4; b = 32'd4; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("start_kill_busy", busy, 0);
    repeat (40) @(negedge clk);
    check("start_kill_result", result, 32'h0000_0012);

    // Reset mid-CALC
    issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    issue(3'b010, 32'hFFFF_FFFE, 32'h0000_0003, model(3'b010, 32'hFFFF_FFFE, 32'h3), 1'b1);
    drain("post_rst");

    // Random back-to-back sweep against the reference model
    for (int i = 0; i < 1000; i++) begin
      rf = 3'($urandom);
      rx = pick();
      ry = pick();
      issue(rf, rx, ry, model(rf, rx, ry), 1'b1);
      repeat (33) @(negedge clk);
    end
    drain("sweep");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
